// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller: sequences the min:sec:msec counters from the 1 ms
// tick and selects live or lap-frozen values for the display.
module stopwatch_ctrl #(
    parameter int unsigned MSEC_MAX = 999,
    parameter int unsigned SEC_MAX  = 59,
    parameter int unsigned MIN_MAX  = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_msec,
    input  logic       btn_run,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [9:0] disp_msec,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic [1:0] state,
    output logic       running,
    output logic       overflow
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StLap   = 2'b11
    } state_e;

    localparam logic [9:0] MsecLast = MSEC_MAX[9:0];
    localparam logic [5:0] SecLast  = SEC_MAX[5:0];
    localparam logic [5:0] MinLast  = MIN_MAX[5:0];

    state_e     state_q, state_d;
    logic [9:0] cnt_msec_q, cnt_msec_d, lap_msec_q, lap_msec_d;
    logic [5:0] cnt_sec_q, cnt_sec_d, lap_sec_q, lap_sec_d;
    logic [5:0] cnt_min_q, cnt_min_d, lap_min_q, lap_min_d;
    logic       overflow_q, overflow_d;
    logic       step, lap_load, clear_all;

    // Counting is gated by the pre-transition state, so a coincident tick follows the old state.
    assign step = clk_msec & ((state_q == StRun) | (state_q == StLap));

    always_comb begin
        state_d   = state_q;
        lap_load  = 1'b0;
        clear_all = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (btn_run) state_d = StRun;
            end
            StRun: begin
                if (btn_run) begin
                    state_d = StPause;
                end else if (btn_lap) begin
                    state_d  = StLap;
                    lap_load = 1'b1;
                end
            end
            StLap: begin
                if (btn_run) begin
                    state_d = StPause;
                end else if (btn_lap) begin
                    state_d = StRun;
                end
            end
            StPause: begin
                if (btn_clear) begin
                    state_d   = StIdle;
                    clear_all = 1'b1;
                end else if (btn_run) begin
                    state_d = StRun;
                end
            end
        endcase
    end

    always_comb begin
        cnt_msec_d = cnt_msec_q;
        cnt_sec_d  = cnt_sec_q;
        cnt_min_d  = cnt_min_q;
        lap_msec_d = lap_msec_q;
        lap_sec_d  = lap_sec_q;
        lap_min_d  = lap_min_q;
        overflow_d = 1'b0;

        // Latch takes the pre-increment value even when a tick lands on the same cycle.
        if (lap_load) begin
            lap_msec_d = cnt_msec_q;
            lap_sec_d  = cnt_sec_q;
            lap_min_d  = cnt_min_q;
        end

        if (clear_all) begin
            cnt_msec_d = '0;
            cnt_sec_d  = '0;
            cnt_min_d  = '0;
            lap_msec_d = '0;
            lap_sec_d  = '0;
            lap_min_d  = '0;
        end else if (step) begin
            if (cnt_msec_q != MsecLast) begin
                cnt_msec_d = cnt_msec_q + 10'd1;
            end else begin
                cnt_msec_d = '0;
                if (cnt_sec_q != SecLast) begin
                    cnt_sec_d = cnt_sec_q + 6'd1;
                end else begin
                    cnt_sec_d = '0;
                    if (cnt_min_q != MinLast) begin
                        cnt_min_d = cnt_min_q + 6'd1;
                    end else begin
                        cnt_min_d  = '0;
                        overflow_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_msec_q <= '0;
            cnt_sec_q  <= '0;
            cnt_min_q  <= '0;
            lap_msec_q <= '0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_msec_q <= cnt_msec_d;
            cnt_sec_q  <= cnt_sec_d;
            cnt_min_q  <= cnt_min_d;
            lap_msec_q <= lap_msec_d;
            lap_sec_q  <= lap_sec_d;
            lap_min_q  <= lap_min_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        if (state_q == StLap) begin
            disp_msec = lap_msec_q;
            disp_sec  = lap_sec_q;
            disp_min  = lap_min_q;
        end else begin
            disp_msec = cnt_msec_q;
            disp_sec  = cnt_sec_q;
            disp_min  = cnt_min_q;
        end
    end

    assign state    = state_q;
    assign running  = (state_q == StRun) | (state_q == StLap);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: three parameterisations share one stimulus stream and are checked
// every cycle against an elapsed-milliseconds model, plus directed literal checks.
module tb_stopwatch_ctrl;

    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int PAUSE = 2;
    localparam int LAP   = 3;

    // Per-instance radices: msec steps per second, seconds per minute, minutes per wrap.
    localparam int MSP [3] = '{1000, 1000, 10};
    localparam int SSP [3] = '{60, 2, 4};
    localparam int MNP [3] = '{60, 1, 3};

    logic clk, reset, clk_msec, btn_run, btn_lap, btn_clear;
    logic [9:0] d_msec  [3];
    logic [5:0] d_sec   [3];
    logic [5:0] d_min   [3];
    logic [1:0] d_state [3];
    logic       d_run   [3];
    logic       d_ovf   [3];

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl u_dut0 (
        .clk(clk), .reset(reset), .clk_msec(clk_msec), .btn_run(btn_run), .btn_lap(btn_lap),
        .btn_clear(btn_clear), .disp_msec(d_msec[0]), .disp_sec(d_sec[0]), .disp_min(d_min[0]),
        .state(d_state[0]), .running(d_run[0]), .overflow(d_ovf[0])
    );

    stopwatch_ctrl #(.MSEC_MAX(999), .SEC_MAX(1), .MIN_MAX(0)) u_dut1 (
        .clk(clk), .reset(reset), .clk_msec(clk_msec), .btn_run(btn_run), .btn_lap(btn_lap),
        .btn_clear(btn_clear), .disp_msec(d_msec[1]), .disp_sec(d_sec[1]), .disp_min(d_min[1]),
        .state(d_state[1]), .running(d_run[1]), .overflow(d_ovf[1])
    );

    stopwatch_ctrl #(.MSEC_MAX(9), .SEC_MAX(3), .MIN_MAX(2)) u_dut2 (
        .clk(clk), .reset(reset), .clk_msec(clk_msec), .btn_run(btn_run), .btn_lap(btn_lap),
        .btn_clear(btn_clear), .disp_msec(d_msec[2]), .disp_sec(d_sec[2]), .disp_min(d_min[2]),
        .state(d_state[2]), .running(d_run[2]), .overflow(d_ovf[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: elapsed time as a single millisecond total modulo the wrap period.
    int m_state [3];
    int m_total [3];
    int m_lap   [3];
    int m_ovf   [3];
    bit started = 1'b0;
    int nxt;
    bit counting, load, wipe;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_state[k] = IDLE;
                m_total[k] = 0;
                m_lap[k]   = 0;
                m_ovf[k]   = 0;
            end else begin
                counting = clk_msec && (m_state[k] == RUN || m_state[k] == LAP);
                nxt  = m_state[k];
                load = 1'b0;
                wipe = 1'b0;
                case (m_state[k])
                    IDLE: if (btn_run) nxt = RUN;
                    RUN: begin
                        if (btn_run) nxt = PAUSE;
                        else if (btn_lap) begin nxt = LAP; load = 1'b1; end
                    end
                    LAP: begin
                        if (btn_run) nxt = PAUSE;
                        else if (btn_lap) nxt = RUN;
                    end
                    default: begin
                        if (btn_clear) begin nxt = IDLE; wipe = 1'b1; end
                        else if (btn_run) nxt = RUN;
                    end
                endcase
                m_ovf[k] = 0;
                if (load) m_lap[k] = m_total[k];
                if (wipe) begin
                    m_total[k] = 0;
                    m_lap[k]   = 0;
                end else if (counting) begin
                    m_total[k] = m_total[k] + 1;
                    if (m_total[k] == MSP[k] * SSP[k] * MNP[k]) begin
                        m_total[k] = 0;
                        m_ovf[k]   = 1;
                    end
                end
                m_state[k] = nxt;
            end
        end
        started = 1'b1;
    end

    task automatic check(input int k, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0d, expected %0d at %0t", k, name, act, exp, $time);
        end
    endtask

    int shown;
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                shown = (m_state[k] == LAP) ? m_lap[k] : m_total[k];
                check(k, "disp_msec", int'(d_msec[k]), shown % MSP[k]);
                check(k, "disp_sec", int'(d_sec[k]), (shown / MSP[k]) % SSP[k]);
                check(k, "disp_min", int'(d_min[k]), shown / (MSP[k] * SSP[k]));
                check(k, "state", int'(d_state[k]), m_state[k]);
                check(k, "running", int'(d_run[k]),
                      (m_state[k] == RUN || m_state[k] == LAP) ? 1 : 0);
                check(k, "overflow", int'(d_ovf[k]), m_ovf[k]);
            end
        end
    end

    task automatic drive(input logic r, input logic run, input logic lap, input logic clr,
                         input logic tk);
        reset     = r;
        btn_run   = run;
        btn_lap   = lap;
        btn_clear = clr;
        clk_msec  = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Ticks are spaced one cycle apart since a tick is only ever one cycle wide.
    task automatic ticks(input int n);
        repeat (n) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            idle_cycle();
        end
    endtask

    task automatic restart_run();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lit(input int k, input int st, input int mn, input int sc, input int ms);
        check(k, "lit_state", int'(d_state[k]), st);
        check(k, "lit_min", int'(d_min[k]), mn);
        check(k, "lit_sec", int'(d_sec[k]), sc);
        check(k, "lit_msec", int'(d_msec[k]), ms);
    endtask

    bit prev_tick;
    logic rr, rn, lp, cl, tk;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        lit(0, IDLE, 0, 0, 0);
        check(0, "lit_running_reset", int'(d_run[0]), 0);
        check(0, "lit_overflow_reset", int'(d_ovf[0]), 0);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1500);
        lit(0, RUN, 0, 1, 500);
        check(0, "lit_running_run", int'(d_run[0]), 1);

        restart_run();
        ticks(250);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(100);
        lit(0, PAUSE, 0, 0, 250);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(10);
        lit(0, RUN, 0, 0, 260);

        restart_run();
        ticks(2000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(500);
        lit(0, LAP, 0, 2, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        lit(0, RUN, 0, 2, 500);

        restart_run();
        ticks(9);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        lit(0, PAUSE, 0, 0, 10);

        restart_run();
        ticks(100);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        lit(0, LAP, 0, 0, 100);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        lit(0, PAUSE, 0, 0, 101);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        lit(0, IDLE, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        lit(0, RUN, 0, 0, 5);

        restart_run();
        ticks(1999);
        lit(1, RUN, 0, 1, 999);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        lit(1, RUN, 0, 0, 0);
        check(1, "lit_overflow_pulse", int'(d_ovf[1]), 1);
        idle_cycle();
        check(1, "lit_overflow_drop", int'(d_ovf[1]), 0);

        prev_tick = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            rn = ($urandom_range(0, 24) == 0);
            lp = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 24) == 0);
            tk = !prev_tick && ($urandom_range(0, 1) == 1);
            drive(rr, rn, lp, cl, tk);
            prev_tick = tk;
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
